// File: rtl/asteroid_pkg.sv
// Shared types and helpers for the asteroid sprite blocks: coordinate widths,
// the explosion FSM state type and the on-screen clamp used at hit capture.
package asteroid_pkg;

    localparam int COORD_W  = 10;
    localparam int POS_W    = 33;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int EXTENT   = 20;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHOW,
        COOLDOWN
    } expl_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] h;
        logic [COORD_W-1:0] v;
    } pos_t;

    // Keeps a sprite centre far enough from the edges that the whole sprite is visible.
    function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] val,
                                                 input int lo, input int hi);
        int x;
        x = int'(val);
        if (x < lo) begin
            x = lo;
        end else if (x > hi) begin
            x = hi;
        end
        return COORD_W'(x);
    endfunction

endpackage

// File: rtl/explosion_sequencer_if.sv
// Hit-event inputs and renderer-facing outputs of the explosion sequencer.
// The master side is collision logic / VGA timing; the slave side is the sequencer.
interface explosion_sequencer_if;
    import asteroid_pkg::*;

    logic               vsync;
    logic               hit;
    logic [COORD_W-1:0] hit_h;
    logic [COORD_W-1:0] hit_v;
    logic               destroy;
    logic [POS_W-1:0]   dH;
    logic [POS_W-1:0]   dV;
    logic [1:0]         phase;
    logic               busy;
    logic               done;
    logic [7:0]         drop_cnt;

    modport master (
        output vsync, hit, hit_h, hit_v,
        input  destroy, dH, dV, phase, busy, done, drop_cnt
    );

    modport slave (
        input  vsync, hit, hit_h, hit_v,
        output destroy, dH, dV, phase, busy, done, drop_cnt
    );

endinterface

// File: rtl/explosion_sequencer_frame_tick_gen.sv
// Turns the level vsync from VGA timing into a registered one-cycle frame tick,
// asserted the cycle after vsync is first seen high.
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic tick
);

    logic vsync_q, vsync_d;
    logic tick_q, tick_d;

    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        vsync_d = vsync;
        tick_d  = vsync & ~vsync_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: flops use <= so every register samples the pre-edge values of the others.
        if (reset) begin
            // A vsync already high when reset releases is a frame in progress, not a new one.
            vsync_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            vsync_q <= vsync_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/explosion_sequencer.sv
// Frame-synchronous explosion sequencer: captures clamped hit positions, plays a
// blinking destroy animation for the renderer, and queues at most one extra hit.
module explosion_sequencer
    import asteroid_pkg::*;
#(
    parameter int SHOW_FRAMES     = 30,
    parameter int BLINK_FRAMES    = 4,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    explosion_sequencer_if.slave bus
);

    localparam int FRAME_W = $clog2(SHOW_FRAMES);
    localparam int COOL_W  = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SHOW_FRAMES - 1);
    localparam logic [COOL_W-1:0]  COOL_LAST  = COOL_W'(COOLDOWN_FRAMES - 1);

    function automatic logic blink_on(input logic [FRAME_W-1:0] f);
        return ((32'(f) / BLINK_FRAMES) % 2) == 0;
    endfunction

    function automatic logic [1:0] phase_of(input logic [FRAME_W-1:0] f);
        int unsigned p;
        p = (32'(f) * 4) / SHOW_FRAMES;
        return (p > 3) ? 2'd3 : p[1:0];
    endfunction

    expl_state_t        state_q, state_d;
    pos_t               stage_q, stage_d;
    pos_t               pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
    logic [COORD_W-1:0] dh_q, dh_d;
    logic [COORD_W-1:0] dv_q, dv_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [COOL_W-1:0]  cool_q, cool_d;
    logic               destroy_q, destroy_d;
    logic [1:0]         phase_q, phase_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         drop_q, drop_d;

    logic tick;
    logic hit_taken;
    pos_t hit_pos;

    frame_tick_gen u_tick (
        .clk   (clk),
        .reset (reset),
        .vsync (bus.vsync),
        .tick  (tick)
    );

    assign hit_pos = '{h: clamp(bus.hit_h, EXTENT, H_ACTIVE - 1 - EXTENT),
                       v: clamp(bus.hit_v, EXTENT, V_ACTIVE - 1 - EXTENT)};

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        dh_d         = dh_q;
        dv_d         = dv_q;
        frame_d      = frame_q;
        cool_d       = cool_q;
        destroy_d    = destroy_q;
        phase_d      = phase_q;
        done_d       = 1'b0;
        drop_d       = drop_q;
        hit_taken    = 1'b0;

        case (state_q)
            IDLE: begin
                // A tick landing with the hit is not consumed; display starts next frame.
                if (bus.hit) begin
                    stage_d   = hit_pos;
                    state_d   = ARMED;
                    hit_taken = 1'b1;
                end
            end
            ARMED: begin
                if (tick) begin
                    dh_d      = stage_q.h;
                    dv_d      = stage_q.v;
                    destroy_d = 1'b1;
                    phase_d   = 2'd0;
                    frame_d   = '0;
                    state_d   = SHOW;
                end
            end
            SHOW: begin
                if (tick) begin
                    if (frame_q == FRAME_LAST) begin
                        destroy_d = 1'b0;
                        phase_d   = 2'd0;
                        done_d    = 1'b1;
                        cool_d    = '0;
                        state_d   = COOLDOWN;
                    end else begin
                        frame_d   = frame_q + 1'b1;
                        destroy_d = blink_on(frame_d);
                        phase_d   = phase_of(frame_d);
                    end
                end
            end
            COOLDOWN: begin
                if (tick) begin
                    if (cool_q == COOL_LAST) begin
                        if (pend_valid_q) begin
                            stage_d      = pend_q;
                            pend_valid_d = 1'b0;
                            state_d      = ARMED;
                        end else if (bus.hit) begin
                            // Nothing queued: a hit arriving now re-arms directly.
                            stage_d   = hit_pos;
                            state_d   = ARMED;
                            hit_taken = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cool_d = cool_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // pend_valid_d already reflects a same-cycle consume, freeing the slot.
        if (bus.hit && !hit_taken) begin
            if (!pend_valid_d) begin
                pend_d       = hit_pos;
                pend_valid_d = 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            stage_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            dh_q         <= '0;
            dv_q         <= '0;
            frame_q      <= '0;
            cool_q       <= '0;
            destroy_q    <= 1'b0;
            phase_q      <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            dh_q         <= dh_d;
            dv_q         <= dv_d;
            frame_q      <= frame_d;
            cool_q       <= cool_d;
            destroy_q    <= destroy_d;
            phase_q      <= phase_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
        end
    end

    assign bus.destroy  = destroy_q;
    assign bus.dH       = POS_W'(dh_q);
    assign bus.dV       = POS_W'(dv_q);
    assign bus.phase    = phase_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_explosion_sequencer.sv
// Self-checking bench for explosion_sequencer: clamp vector table, directed
// multi-frame sequences, and randomized traffic against a job-queue reference model.
module tb_explosion_sequencer;

    localparam int SHOW  = 30;
    localparam int BLINK = 4;
    localparam int COOL  = 8;
    localparam int H_LO = 20, H_HI = 619, V_LO = 20, V_HI = 459;

    logic clk;
    logic reset;
    explosion_sequencer_if ifc ();

    explosion_sequencer #(
        .SHOW_FRAMES     (SHOW),
        .BLINK_FRAMES    (BLINK),
        .COOLDOWN_FRAMES (COOL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit saw_done;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: a queue of jobs (current + at most one waiting) and the
    // number of frames the current job has been on screen (-1 = waiting for a frame).
    typedef struct {
        int h;
        int v;
    } mpos_t;

    mpos_t jobs[$];
    int    m_t = -1;
    bit    m_vs_prev = 1'b1;
    bit    m_tick = 1'b0;
    int    m_dh = 0, m_dv = 0, m_drop = 0;
    bit    m_done = 1'b0;

    function automatic int mclamp(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    task automatic model_step(input bit rst, input bit hit, input int hh, input int hv, input bit vs);
        bit    tick_now;
        mpos_t p;
        if (rst) begin
            jobs.delete();
            m_t = -1; m_vs_prev = 1'b1; m_tick = 1'b0;
            m_dh = 0; m_dv = 0; m_drop = 0; m_done = 1'b0;
            return;
        end
        tick_now  = m_tick;
        m_tick    = vs && !m_vs_prev;
        m_vs_prev = vs;
        m_done    = 1'b0;
        if (tick_now && jobs.size() > 0) begin
            if (m_t == -1) begin
                m_dh = jobs[0].h;
                m_dv = jobs[0].v;
                m_t  = 0;
            end else if (m_t == SHOW + COOL - 1) begin
                void'(jobs.pop_front());
                m_t = -1;
            end else begin
                m_t++;
                if (m_t == SHOW) m_done = 1'b1;
            end
        end
        if (hit) begin
            if (jobs.size() < 2) begin
                p.h = mclamp(hh, H_LO, H_HI);
                p.v = mclamp(hv, V_LO, V_HI);
                jobs.push_back(p);
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
    endtask

    function automatic logic [127:0] model_outputs();
        bit on;
        int ph;
        on = (jobs.size() > 0) && (m_t >= 0) && (m_t < SHOW);
        ph = on ? ((m_t * 4 / SHOW) > 3 ? 3 : (m_t * 4 / SHOW)) : 0;
        return {49'd0, on && ((m_t / BLINK) % 2 == 0), 33'(m_dh), 33'(m_dv), 2'(ph),
                jobs.size() > 0, m_done, 8'(m_drop)};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step(reset, ifc.hit, int'(ifc.hit_h), int'(ifc.hit_v), ifc.vsync);
        #1;
        check("model", {49'd0, ifc.destroy, ifc.dH, ifc.dV, ifc.phase, ifc.busy, ifc.done, ifc.drop_cnt},
              model_outputs());
        if (ifc.done) saw_done = 1'b1;
    endtask

    task automatic hit_cycle(input int h, input int v);
        ifc.hit   = 1'b1;
        ifc.hit_h = 10'(h);
        ifc.hit_v = 10'(v);
        step();
        ifc.hit = 1'b0;
    endtask

    task automatic frame();
        saw_done  = 1'b0;
        ifc.vsync = 1'b1;
        step();
        ifc.vsync = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    typedef struct {
        int h;
        int v;
        int exp_h;
        int exp_v;
    } clamp_vec_t;

    clamp_vec_t vecs[8];

    initial begin
        int found;
        int k_done;
        int flen, fpos, vw;

        vecs[0] = '{100, 200, 100, 200};
        vecs[1] = '{5, 470, 20, 459};
        vecs[2] = '{639, 0, 619, 20};
        vecs[3] = '{20, 20, 20, 20};
        vecs[4] = '{619, 459, 619, 459};
        vecs[5] = '{1023, 1023, 619, 459};
        vecs[6] = '{0, 0, 20, 20};
        vecs[7] = '{620, 460, 619, 459};

        reset = 1'b1;
        ifc.vsync = 1'b0;
        ifc.hit = 1'b0;
        ifc.hit_h = '0;
        ifc.hit_v = '0;
        step();
        step();
        reset = 1'b0;
        check("reset_state", {ifc.destroy, ifc.dH, ifc.dV, ifc.phase, ifc.busy, ifc.done, ifc.drop_cnt}, 0);
        frames(2);

        // Basic sequence: blink pattern, done at the 30th frame tick, 8 frames of cooldown.
        hit_cycle(100, 200);
        check("t1_armed_busy", ifc.busy, 1);
        ifc.vsync = 1'b1;
        step();
        check("t1_not_yet", ifc.destroy, 0);
        ifc.vsync = 1'b0;
        step();
        check("t1_destroy_on", ifc.destroy, 1);
        check("t1_pos", {ifc.dH, ifc.dV}, {33'd100, 33'd200});
        step();
        step();
        for (int n = 1; n < SHOW; n++) begin
            frame();
            check($sformatf("t1_frame%0d", n), {ifc.destroy, saw_done}, {((n / 4) % 2) == 0, 1'b0});
        end
        frame();
        check("t1_done", {saw_done, ifc.destroy, ifc.busy}, 3'b101);
        for (int c = 1; c <= COOL; c++) begin
            frame();
            check($sformatf("t1_cool%0d", c), ifc.busy, c < COOL);
        end

        // Clamp table.
        foreach (vecs[i]) begin
            hit_cycle(vecs[i].h, vecs[i].v);
            frame();
            check($sformatf("clamp%0d", i), {ifc.destroy, ifc.dH, ifc.dV},
                  {1'b1, 33'(vecs[i].exp_h), 33'(vecs[i].exp_v)});
            frames(38);
            check($sformatf("clamp%0d_idle", i), ifc.busy, 0);
        end

        // Three hits during SHOW: second queued, third dropped.
        hit_cycle(300, 100);
        frames(2);
        hit_cycle(400, 300);
        hit_cycle(500, 50);
        check("t3_drop", ifc.drop_cnt, 1);
        found = 0;
        for (int k = 0; k < 45 && found == 0; k++) begin
            frame();
            if (saw_done) found = 1;
        end
        check("t3_first_done", found, 1);
        found = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            frame();
            if (ifc.destroy) found = 1;
        end
        check("t3_second_start", found, 1);
        check("t3_second_pos", {ifc.dH, ifc.dV}, {33'd400, 33'd300});
        frames(38);
        check("t3_idle", ifc.busy, 0);

        // Hit coincident with a tick in IDLE: that tick is not consumed.
        ifc.vsync = 1'b1;
        step();
        ifc.vsync = 1'b0;
        hit_cycle(50, 60);
        step();
        step();
        check("t4_wait", {ifc.destroy, ifc.busy}, 2'b01);
        frame();
        check("t4_start", {ifc.destroy, ifc.dH, ifc.dV}, {1'b1, 33'd50, 33'd60});
        frames(38);

        // Reset mid-SHOW with a hit pending.
        hit_cycle(200, 150);
        frames(3);
        hit_cycle(210, 160);
        frames(8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_reset", {ifc.destroy, ifc.busy, ifc.dH, ifc.dV, ifc.drop_cnt}, 0);
        frames(3);
        check("t5_no_pending", ifc.busy, 0);
        hit_cycle(250, 250);
        frame();
        k_done = 0;
        for (int k = 1; k <= 40 && k_done == 0; k++) begin
            frame();
            if (saw_done) k_done = k;
        end
        check("t5_len", k_done, SHOW);
        frames(COOL);
        check("t5_idle", ifc.busy, 0);

        // Drop counter saturation.
        hit_cycle(10, 10);
        for (int i = 0; i < 301; i++) hit_cycle(i, i);
        check("t6_sat", ifc.drop_cnt, 255);
        frames(80);
        check("t6_end", {ifc.busy, ifc.drop_cnt}, {1'b0, 8'd255});

        // Randomized traffic, occasional reset.
        flen = 4; fpos = 0; vw = 1;
        for (int c = 0; c < 4000; c++) begin
            if (fpos == 0) begin
                flen = $urandom_range(3, 8);
                vw   = $urandom_range(1, 2);
            end
            ifc.vsync = (fpos < vw);
            ifc.hit   = ($urandom_range(0, 11) == 0);
            ifc.hit_h = 10'($urandom_range(0, 1023));
            ifc.hit_v = 10'($urandom_range(0, 1023));
            reset     = ($urandom_range(0, 799) == 0);
            step();
            fpos = (fpos + 1 == flen) ? 0 : fpos + 1;
        end
        ifc.hit = 1'b0;
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
